// File: rtl/cp0_vic.sv
// ---------------------------------------------------------------------------
// cp0_vic : coprocessor-0 with a vectored, nested interrupt controller.
//
// Holds the CP0 register file and an EPC/level stack for nested service.
// Internal exceptions and maskable, priority-ordered external interrupts
// push the stack and force a jump. ERET pops the stack and jumps back.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   debug_addr_cp0      debug register select
//   debug_data_cp0      combinational read of debug_addr_cp0
//   cp_oper             0 none, 1 MTC0, 2 MFC0, 3 ERET, others none
//   addr_r              MFC0 register address
//   data_readFromCP0    registered MFC0 result, held until the next MFC0
//   addr_w              MTC0 register address
//   data_writeToCP0     MTC0 data
//   cause               internal exception code, 0 = no exception
//   interruptSignal     level-sensitive external requests (N_IRQ-1 highest)
//   except_ret_addr     return address pushed on exception/interrupt entry
//   epc_ctrl            one-cycle force-jump pulse
//   jumpAddressExcept   jump target, valid while epc_ctrl = 1
//   exceptClear         one-cycle flush pulse on exception/interrupt entry
//   nest_level          current stack occupancy
// ---------------------------------------------------------------------------
module cp0_vic #(
   parameter int          N_IRQ       = 4,
   parameter int          NEST_DEPTH  = 4,
   parameter logic [31:0] VECTOR_BASE = 32'h0000_0024
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [4:0]                      debug_addr_cp0,
   output logic [31:0]                     debug_data_cp0,
   input  logic [2:0]                      cp_oper,
   input  logic [4:0]                      addr_r,
   output logic [31:0]                     data_readFromCP0,
   input  logic [4:0]                      addr_w,
   input  logic [31:0]                     data_writeToCP0,
   input  logic [4:0]                      cause,
   input  logic [N_IRQ-1:0]                interruptSignal,
   input  logic [31:0]                     except_ret_addr,
   output logic                            epc_ctrl,
   output logic [31:0]                     jumpAddressExcept,
   output logic                            exceptClear,
   output logic [$clog2(NEST_DEPTH+1)-1:0] nest_level
);

   localparam int SPW = $clog2(NEST_DEPTH + 1);
   localparam int IW  = $clog2(NEST_DEPTH);
   localparam int LW  = $clog2(N_IRQ + 2);

   localparam logic [4:0] A_STATUS = 5'd12;
   localparam logic [4:0] A_CAUSE  = 5'd13;
   localparam logic [4:0] A_EPC    = 5'd14;
   localparam logic [4:0] A_EBASE  = 5'd15;

   localparam logic [LW-1:0]  EXC_LVL = LW'(N_IRQ + 1);
   localparam logic [SPW-1:0] FULL_SP = SPW'(NEST_DEPTH);

   // architectural state
   logic [31:0]   regs [32];
   logic [31:0]   status_q;
   logic [31:0]   ebase_q;
   logic [4:0]    exc_code_q;
   logic          sov_q;
   logic [SPW-1:0] sp_q;
   logic [LW-1:0] lvl_q;
   logic [31:0]   stk_epc [NEST_DEPTH];
   logic [LW-1:0] stk_lvl [NEST_DEPTH];

   // decoded operation and event signals
   logic          is_mtc0, is_mfc0, is_eret;
   logic          wr_status, wr_cause, wr_ebase, wr_gpr;
   logic          stack_full, stack_empty;
   logic [IW-1:0] top_idx, push_idx;
   logic [N_IRQ-1:0] masked;
   logic          irq_any;
   logic [LW-1:0] irq_lvl;
   logic          take_exc, take_irq, take_eret, take_any;
   logic [31:0]   irq_target, target;
   logic [31:0]   epc_view, cause_view;
   logic [31:0]   mfc0_val;

   assign nest_level = sp_q;

   // Operation decode. MTC0 to EPC (and everything else that is not a
   // special register) is routed away from the special registers here.
   always_comb begin
      is_mtc0   = (cp_oper == 3'd1);
      is_mfc0   = (cp_oper == 3'd2);
      is_eret   = (cp_oper == 3'd3);
      wr_status = is_mtc0 && (addr_w == A_STATUS);
      wr_cause  = is_mtc0 && (addr_w == A_CAUSE);
      wr_ebase  = is_mtc0 && (addr_w == A_EBASE);
      wr_gpr    = is_mtc0 && (addr_w != A_STATUS) && (addr_w != A_CAUSE) &&
                  (addr_w != A_EPC) && (addr_w != A_EBASE);
   end

   // Stack pointer bookkeeping. When the stack is full an exception
   // overwrites the top entry instead of growing the stack.
   always_comb begin
      stack_full  = (sp_q == FULL_SP);
      stack_empty = (sp_q == '0);
      top_idx     = IW'(sp_q - SPW'(1));
      push_idx    = stack_full ? top_idx : IW'(sp_q);
      epc_view    = stack_empty ? 32'd0 : stk_epc[top_idx];
   end

   // Priority encoder: the last (highest-numbered) masked request wins.
   // The level it would run at is its index plus one.
   always_comb begin
      masked  = interruptSignal & status_q[8 +: N_IRQ];
      irq_any = 1'b0;
      irq_lvl = '0;
      for (int k = 0; k < N_IRQ; k++) begin
         if (masked[k]) begin
            irq_any = 1'b1;
            irq_lvl = LW'(k + 1);
         end
      end
   end

   // Event arbitration: exception > interrupt > ERET. An interrupt only
   // preempts strictly lower levels, so a held request cannot re-enter
   // its own handler. Vector spacing is 8 bytes per level.
   always_comb begin
      take_exc   = (cause != 5'd0);
      take_irq   = !take_exc && status_q[0] && irq_any &&
                   (irq_lvl > lvl_q) && !stack_full;
      take_eret  = is_eret && !take_exc && !take_irq && !stack_empty;
      take_any   = take_exc || take_irq || take_eret;
      irq_target = ebase_q + {{(32-LW-3){1'b0}}, irq_lvl, 3'b000};
      target     = 32'd0;
      if (take_exc)
         target = ebase_q;
      else if (take_irq)
         target = irq_target;
      else if (take_eret)
         target = stk_epc[top_idx];
   end

   // Cause as software sees it: IP is the live request lines, not a
   // stored copy.
   always_comb begin
      cause_view              = 32'd0;
      cause_view[31]          = sov_q;
      cause_view[6:2]         = exc_code_q;
      cause_view[8 +: N_IRQ]  = interruptSignal;
   end

   function automatic logic [31:0] read_cp0(input logic [4:0] a);
      logic [31:0] v;
      case (a)
         A_STATUS: v = status_q;
         A_CAUSE:  v = cause_view;
         A_EPC:    v = epc_view;
         A_EBASE:  v = ebase_q;
         default:  v = regs[a];
      endcase
      return v;
   endfunction

   // Read ports: the debug port is purely combinational, the MFC0 value
   // is captured into data_readFromCP0 at the edge.
   always_comb begin
      debug_data_cp0 = read_cp0(debug_addr_cp0);
      mfc0_val       = read_cp0(addr_r);
   end

   // General-purpose CP0 registers, written only by MTC0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++)
            regs[i] <= 32'd0;
      end else if (wr_gpr) begin
         regs[addr_w] <= data_writeToCP0;
      end
   end

   // Status and EBASE are software-owned; hardware never modifies them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status_q <= 32'd0;
         ebase_q  <= VECTOR_BASE;
      end else begin
         if (wr_status)
            status_q <= data_writeToCP0;
         if (wr_ebase)
            ebase_q <= data_writeToCP0;
      end
   end

   // Cause fields: a hardware exception beats a simultaneous MTC0.
   // SOV can only be cleared by software, and a same-cycle overflow
   // keeps it set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exc_code_q <= 5'd0;
         sov_q      <= 1'b0;
      end else begin
         if (take_exc)
            exc_code_q <= cause;
         else if (wr_cause)
            exc_code_q <= data_writeToCP0[6:2];
         if (take_exc && stack_full)
            sov_q <= 1'b1;
         else if (wr_cause && !data_writeToCP0[31])
            sov_q <= 1'b0;
      end
   end

   // EPC/level stack and the current level. Entry pushes the level being
   // left so ERET can restore it along with the return address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp_q  <= '0;
         lvl_q <= '0;
         for (int i = 0; i < NEST_DEPTH; i++) begin
            stk_epc[i] <= 32'd0;
            stk_lvl[i] <= '0;
         end
      end else if (take_exc || take_irq) begin
         stk_epc[push_idx] <= except_ret_addr;
         stk_lvl[push_idx] <= lvl_q;
         if (!stack_full)
            sp_q <= sp_q + SPW'(1);
         lvl_q <= take_exc ? EXC_LVL : irq_lvl;
      end else if (take_eret) begin
         sp_q  <= sp_q - SPW'(1);
         lvl_q <= stk_lvl[top_idx];
      end
   end

   // Registered outputs: jump/flush pulses last exactly one cycle, the
   // MFC0 result holds until the next MFC0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         epc_ctrl          <= 1'b0;
         jumpAddressExcept <= 32'd0;
         exceptClear       <= 1'b0;
         data_readFromCP0  <= 32'd0;
      end else begin
         epc_ctrl          <= take_any;
         jumpAddressExcept <= target;
         exceptClear       <= take_exc || take_irq;
         if (is_mfc0)
            data_readFromCP0 <= mfc0_val;
      end
   end

endmodule

// File: tb/tb_cp0_vic.sv
// ---------------------------------------------------------------------------
// tb_cp0_vic : self-checking bench for cp0_vic.
//
// A behavioural model (queue stack, integer level) predicts every jump and
// every MFC0 result; predictions go into scoreboard queues stamped with the
// cycle they should appear in, and a monitor on the falling edge pops and
// compares them. Directed sequences cover the nesting, priority, overflow
// and reset cases; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_cp0_vic;

   localparam int          N   = 4;
   localparam int          ND  = 4;
   localparam logic [31:0] VB  = 32'h0000_0024;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  debug_addr_cp0;
   logic [31:0] debug_data_cp0;
   logic [2:0]  cp_oper;
   logic [4:0]  addr_r;
   logic [31:0] data_readFromCP0;
   logic [4:0]  addr_w;
   logic [31:0] data_writeToCP0;
   logic [4:0]  cause;
   logic [N-1:0] interruptSignal;
   logic [31:0] except_ret_addr;
   logic        epc_ctrl;
   logic [31:0] jumpAddressExcept;
   logic        exceptClear;
   logic [2:0]  nest_level;

   cp0_vic #(.N_IRQ(N), .NEST_DEPTH(ND), .VECTOR_BASE(VB)) dut (
      .clk               (clk),
      .rst               (rst),
      .debug_addr_cp0    (debug_addr_cp0),
      .debug_data_cp0    (debug_data_cp0),
      .cp_oper           (cp_oper),
      .addr_r            (addr_r),
      .data_readFromCP0  (data_readFromCP0),
      .addr_w            (addr_w),
      .data_writeToCP0   (data_writeToCP0),
      .cause             (cause),
      .interruptSignal   (interruptSignal),
      .except_ret_addr   (except_ret_addr),
      .epc_ctrl          (epc_ctrl),
      .jumpAddressExcept (jumpAddressExcept),
      .exceptClear       (exceptClear),
      .nest_level        (nest_level)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int nTests = 0;
   int nFail  = 0;

   // scoreboard records
   typedef struct {
      int          stamp;
      logic [31:0] jump;
      logic        clr;
      int          nest;
   } jrec_t;

   typedef struct {
      int          stamp;
      logic [31:0] data;
   } mrec_t;

   jrec_t jq[$];
   mrec_t mq[$];

   // reference model state
   typedef struct {
      logic [31:0] epc;
      int          lvl;
   } ent_t;

   ent_t        mStk[$];
   int          mLvl;
   logic [31:0] mStatus;
   logic [31:0] mEbase;
   logic [4:0]  mExc;
   logic        mSov;
   logic [31:0] mRegs [32];

   logic [N-1:0] irqV;
   logic [31:0]  retV;

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic modelReset();
      mStk.delete();
      mLvl    = 0;
      mStatus = 32'd0;
      mEbase  = VB;
      mExc    = 5'd0;
      mSov    = 1'b0;
      for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
   endtask

   function automatic logic [31:0] modelRead(input logic [4:0] a);
      logic [31:0] v;
      v = 32'd0;
      case (a)
         5'd12: v = mStatus;
         5'd13: begin
            v[31]  = mSov;
            v[6:2] = mExc;
            for (int k = 0; k < N; k++) v[8+k] = irqV[k];
         end
         5'd14: v = (mStk.size() > 0) ? mStk[mStk.size()-1].epc : 32'd0;
         5'd15: v = mEbase;
         default: v = mRegs[a];
      endcase
      return v;
   endfunction

   // One clock of stimulus: drive the inputs for the next edge and let
   // the model decide what that edge does.
   task automatic applyStimulus(input logic [2:0] op, input logic [4:0] ar,
                                input logic [4:0] aw, input logic [31:0] wd,
                                input logic [4:0] cs);
      int   p;
      bit   ovf;
      bit   exc;
      ent_t e;
      @(posedge clk);
      #1;
      cp_oper         = op;
      addr_r          = ar;
      addr_w          = aw;
      data_writeToCP0 = wd;
      cause           = cs;
      interruptSignal = irqV;
      except_ret_addr = retV;

      if (op == 3'd2)
         mq.push_back('{cyc + 1, modelRead(ar)});

      exc = (cs != 5'd0);
      ovf = 1'b0;
      p   = -1;
      for (int k = 0; k < N; k++)
         if (irqV[k] && mStatus[8+k]) p = k;

      if (exc) begin
         e = '{retV, mLvl};
         if (mStk.size() == ND) begin
            mStk[mStk.size()-1] = e;
            mSov = 1'b1;
            ovf  = 1'b1;
         end else begin
            mStk.push_back(e);
         end
         jq.push_back('{cyc + 1, mEbase, 1'b1, mStk.size()});
         mExc = cs;
         mLvl = N + 1;
      end else if (mStatus[0] && p >= 0 && (p + 1) > mLvl && mStk.size() < ND) begin
         mStk.push_back('{retV, mLvl});
         mLvl = p + 1;
         jq.push_back('{cyc + 1, mEbase + 32'(8 * (p + 1)), 1'b1, mStk.size()});
      end else if (op == 3'd3 && mStk.size() > 0) begin
         e    = mStk.pop_back();
         mLvl = e.lvl;
         jq.push_back('{cyc + 1, e.epc, 1'b0, mStk.size()});
      end

      if (op == 3'd1) begin
         case (aw)
            5'd12: mStatus = wd;
            5'd13: begin
               if (!exc) mExc = wd[6:2];
               if (!wd[31] && !ovf) mSov = 1'b0;
            end
            5'd14: ;
            5'd15: mEbase = wd;
            default: mRegs[aw] = wd;
         endcase
      end
   endtask

   // Monitor: compares DUT outputs with queued predictions once per cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (jq.size() > 0 && jq[0].stamp == cyc) begin
            if (epc_ctrl) begin
               checkOutput("jump_addr", jumpAddressExcept, jq[0].jump);
               checkOutput("except_clear", {31'd0, exceptClear}, {31'd0, jq[0].clr});
               checkOutput("nest_after_jump", {29'd0, nest_level}, 32'(jq[0].nest));
            end else begin
               checkOutput("epc_ctrl_missing", {31'd0, epc_ctrl}, 32'd1);
            end
            void'(jq.pop_front());
         end else if (epc_ctrl || exceptClear) begin
            checkOutput("epc_ctrl_unexpected", {31'd0, epc_ctrl | exceptClear}, 32'd0);
         end
         if (mq.size() > 0 && mq[0].stamp == cyc) begin
            checkOutput("mfc0_data", data_readFromCP0, mq[0].data);
            void'(mq.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [2:0]  op;
      logic [4:0]  aw;
      logic [31:0] wd;
      logic [4:0]  cs;
      int          r;

      rst = 1'b1;
      debug_addr_cp0 = 5'd15;
      cp_oper = 3'd0; addr_r = 5'd0; addr_w = 5'd0; data_writeToCP0 = 32'd0;
      cause = 5'd0; interruptSignal = '0; except_ret_addr = 32'd0;
      irqV = '0; retV = 32'd0;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      checkOutput("rst_epc_ctrl", {31'd0, epc_ctrl}, 32'd0);
      checkOutput("rst_clear", {31'd0, exceptClear}, 32'd0);
      checkOutput("rst_jump", jumpAddressExcept, 32'd0);
      checkOutput("rst_mfc0", data_readFromCP0, 32'd0);
      checkOutput("rst_nest", {29'd0, nest_level}, 32'd0);
      checkOutput("rst_debug_ebase", debug_data_cp0, 32'h24);

      // basic reads
      applyStimulus(3'd2, 5'd15, 5'd0, 32'd0, 5'd0);
      applyStimulus(3'd2, 5'd14, 5'd0, 32'd0, 5'd0);
      checkOutput("read_ebase", data_readFromCP0, 32'h24);
      applyStimulus(3'd1, 5'd0, 5'd12, 32'h0000_0301, 5'd0);
      checkOutput("read_epc_empty", data_readFromCP0, 32'h0);

      // IRQ1 entry
      irqV = 4'b0010; retV = 32'h40;
      applyStimulus(3'd0, 5'd0, 5'd0, 32'd0, 5'd0);
      applyStimulus(3'd2, 5'd14, 5'd0, 32'd0, 5'd0);
      checkOutput("irq1_pulse", {31'd0, epc_ctrl}, 32'd1);
      checkOutput("irq1_jump", jumpAddressExcept, 32'h34);
      checkOutput("irq1_clear", {31'd0, exceptClear}, 32'd1);
      applyStimulus(3'd0, 5'd0, 5'd0, 32'd0, 5'd0);
      checkOutput("irq1_epc", data_readFromCP0, 32'h40);
      checkOutput("irq1_nest", {29'd0, nest_level}, 32'd1);
      checkOutput("irq1_single_pulse", {31'd0, epc_ctrl}, 32'd0);

      // lower-priority IRQ0 does not preempt
      irqV = 4'b0011;
      applyStimulus(3'd0, 5'd0, 5'd0, 32'd0, 5'd0);
      applyStimulus(3'd0, 5'd0, 5'd0, 32'd0, 5'd0);
      checkOutput("irq0_blocked", {31'd0, epc_ctrl}, 32'd0);

      // IRQ3 nests on top
      applyStimulus(3'd1, 5'd0, 5'd12, 32'h0000_0B01, 5'd0);
      irqV = 4'b1011; retV = 32'h80;
      applyStimulus(3'd0, 5'd0, 5'd0, 32'd0, 5'd0);
      applyStimulus(3'd0, 5'd0, 5'd0, 32'd0, 5'd0);
      checkOutput("irq3_jump", jumpAddressExcept, 32'h44);
      checkOutput("irq3_nest", {29'd0, nest_level}, 32'd2);
      irqV = 4'b0000;
      applyStimulus(3'd3, 5'd0, 5'd0, 32'd0, 5'd0);
      applyStimulus(3'd3, 5'd0, 5'd0, 32'd0, 5'd0);
      checkOutput("eret1_jump", jumpAddressExcept, 32'h80);
      checkOutput("eret1_noclear", {31'd0, exceptClear}, 32'd0);
      applyStimulus(3'd0, 5'd0, 5'd0, 32'd0, 5'd0);
      checkOutput("eret2_jump", jumpAddressExcept, 32'h40);
      checkOutput("eret2_nest", {29'd0, nest_level}, 32'd0);

      // exception beats a simultaneous interrupt
      irqV = 4'b1000; retV = 32'h100;
      applyStimulus(3'd0, 5'd0, 5'd0, 32'd0, 5'd2);
      applyStimulus(3'd2, 5'd13, 5'd0, 32'd0, 5'd0);
      checkOutput("exc_jump", jumpAddressExcept, 32'h24);
      applyStimulus(3'd0, 5'd0, 5'd0, 32'd0, 5'd0);
      checkOutput("exc_cause", data_readFromCP0, 32'h0000_0808);
      checkOutput("irq3_under_exc", {31'd0, epc_ctrl}, 32'd0);
      irqV = 4'b0000;
      applyStimulus(3'd3, 5'd0, 5'd0, 32'd0, 5'd0);
      applyStimulus(3'd0, 5'd0, 5'd0, 32'd0, 5'd0);

      // overflow the stack with back-to-back exceptions
      for (int i = 0; i <= ND; i++) begin
         retV = 32'h200 + 32'(4 * i);
         applyStimulus(3'd0, 5'd0, 5'd0, 32'd0, 5'd3);
      end
      applyStimulus(3'd2, 5'd13, 5'd0, 32'd0, 5'd0);
      applyStimulus(3'd2, 5'd14, 5'd0, 32'd0, 5'd0);
      checkOutput("ovf_cause", data_readFromCP0, 32'h8000_000C);
      checkOutput("ovf_nest", {29'd0, nest_level}, 32'(ND));
      applyStimulus(3'd0, 5'd0, 5'd0, 32'd0, 5'd0);
      checkOutput("ovf_top_epc", data_readFromCP0, 32'h210);
      for (int i = 0; i <= ND; i++)
         applyStimulus(3'd3, 5'd0, 5'd0, 32'd0, 5'd0);
      applyStimulus(3'd0, 5'd0, 5'd0, 32'd0, 5'd0);
      checkOutput("eret_empty", {31'd0, epc_ctrl}, 32'd0);
      applyStimulus(3'd1, 5'd0, 5'd13, 32'd0, 5'd0);
      applyStimulus(3'd2, 5'd13, 5'd0, 32'd0, 5'd0);

      // randomized phase
      for (int n = 0; n < 800; n++) begin
         r = $urandom_range(0, 15);
         if (r <= 5)       op = 3'd0;
         else if (r <= 8)  op = 3'd1;
         else if (r <= 11) op = 3'd2;
         else if (r <= 14) op = 3'd3;
         else              op = 3'($urandom_range(4, 7));
         r = $urandom_range(0, 7);
         if (r <= 2)      aw = 5'd12;
         else if (r == 3) aw = 5'd15;
         else if (r == 4) aw = 5'd13;
         else if (r == 5) aw = 5'd14;
         else             aw = 5'($urandom_range(0, 31));
         wd = $urandom;
         if (aw == 5'd12 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
         if (aw == 5'd13) wd[31] = 1'b0;
         cs = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         if ($urandom_range(0, 3) == 0) irqV = 4'($urandom_range(0, 15));
         retV = $urandom & 32'hFFFF_FFFC;
         applyStimulus(op, 5'($urandom_range(0, 31)), aw, wd, cs);
      end

      // reset while a jump pulse is on the output
      irqV = 4'b0000; retV = 32'h300;
      applyStimulus(3'd1, 5'd0, 5'd15, 32'h0000_1000, 5'd7);
      @(posedge clk);
      #1;
      cp_oper = 3'd0; cause = 5'd0; interruptSignal = '0;
      @(negedge clk);
      #1;
      checkOutput("pre_rst_pulse", {31'd0, epc_ctrl}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_epc_ctrl", {31'd0, epc_ctrl}, 32'd0);
      checkOutput("mid_rst_clear", {31'd0, exceptClear}, 32'd0);
      checkOutput("mid_rst_jump", jumpAddressExcept, 32'd0);
      checkOutput("mid_rst_mfc0", data_readFromCP0, 32'd0);
      checkOutput("mid_rst_nest", {29'd0, nest_level}, 32'd0);
      checkOutput("mid_rst_ebase", debug_data_cp0, 32'h24);
      modelReset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(3'd2, 5'd15, 5'd0, 32'd0, 5'd0);
      applyStimulus(3'd0, 5'd0, 5'd0, 32'd0, 5'd0);
      checkOutput("post_rst_ebase", data_readFromCP0, 32'h24);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("jq_drained", 32'(jq.size()), 32'd0);
      checkOutput("mq_drained", 32'(mq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/cp0_vic.md
# cp0_vic

Parametrised coprocessor-0 with a vectored, nested interrupt controller for the pipelined MIPS core. It replaces the fixed 3-level ring scheme with N_IRQ maskable, priority-ordered interrupt lines, an EPC/level stack of NEST_DEPTH entries for nested service, and per-source vector addresses. It sits beside the ID/EXE stages. It takes MTC0/MFC0/ERET operations and internal exception causes, and drives the PC force-jump path.

## Interface
- N_IRQ, 4: number of external interrupt lines (1..8); line N_IRQ-1 has highest priority.
- NEST_DEPTH, 4: EPC/level stack entries (power of two, ≥2).
- VECTOR_BASE, 32'h0000_0024: reset value of EBASE.
- clk  in  1  main clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- debug_addr_cp0  in  5  debug register select.
- debug_data_cp0  out  32  combinational read of register debug_addr_cp0.
- cp_oper  in  3  0 none, 1 MTC0, 2 MFC0, 3 ERET; other values are treated as none.
- addr_r  in  5  MFC0 register address.
- data_readFromCP0  out  32  registered MFC0 result.
- addr_w  in  5  MTC0 register address.
- data_writeToCP0  in  32  MTC0 data.
- cause  in  5  internal exception code; 0 means no exception.
- interruptSignal  in  N_IRQ  level-sensitive external requests.
- except_ret_addr  in  32  return address saved on exception or interrupt entry.
- epc_ctrl  out  1  one-cycle force-jump pulse.
- jumpAddressExcept  out  32  jump target; valid while epc_ctrl=1.
- exceptClear  out  1  one-cycle pipeline flush pulse.
- nest_level  out  clog2(NEST_DEPTH+1)  current stack occupancy.

## Operation
- Register file: 32×32 general registers, plus the following special registers:
  - Status (12): bit0 IE; bits[8+N_IRQ-1:8] IM (interrupt masks).
  - Cause (13): bits[6:2] ExcCode; bits[8+N_IRQ-1:8] IP, the live copy of interruptSignal (read-only); bit31 SOV, the sticky stack overflow flag, cleared by MTC0 writing 0 to bit31.
  - EPC (14): read-only mirror of the stack-top EPC; 0 when the stack is empty.
  - EBASE (15).
- Current level: lvl = 0 for user, k+1 while servicing IRQ k, N_IRQ+1 while servicing an exception. lvl is kept in the stack alongside the EPC.
- Exception: taken when cause≠0 is sampled. Actions:
  - Push {except_ret_addr, lvl}.
  - Set ExcCode to cause, set lvl to N_IRQ+1, set target to EBASE.
  - If the stack is full, overwrite the top entry and set SOV.
- Interrupt: let p = highest k with interruptSignal[k] & IM[k]. The interrupt is taken when all of these hold: IE=1, no exception, p+1 > lvl, stack not full.
  - Push {except_ret_addr, lvl}, set lvl to p+1, set target to EBASE + 8·(p+1).
  - When the stack is full, interrupts stay pending and are not taken.
- ERET: pop the stack, restore lvl, set target to the popped EPC.
  - ERET with an empty stack produces no jump and no state change.
- Event priority in one cycle: exception > interrupt > ERET. A suppressed ERET is dropped; the pipeline re-issues it.
- MTC0/MFC0 execute in the same cycle as any event.
  - If MTC0 targets a field that hardware updates in that cycle, the hardware update wins.
  - MTC0 to EPC or to the IP bits is ignored.
- MFC0 of EPC returns the stack-top EPC. MFC0 of Cause returns the live IP bits.

## Timing
- Reset values: all outputs 0; all registers 0 except EBASE = VECTOR_BASE; stack empty; lvl 0.
- An event sampled at edge t produces epc_ctrl=1 and a valid jumpAddressExcept from edge t to edge t+1, for exactly one cycle.
- exceptClear=1 in the same cycle as epc_ctrl for exception or interrupt entry only; it stays 0 for ERET.
- Stack, lvl, EPC and Cause update at edge t.
- If cause≠0 is sampled on consecutive cycles, each cycle is a separate exception (pushes again).
- Level-held interrupts do not re-trigger, because p+1 = lvl blocks them.
- MFC0 issued at edge t gives data_readFromCP0 valid from edge t; it holds until the next MFC0.
- Asserting rst mid-operation clears everything immediately; epc_ctrl drops within the same cycle.

## Test plan
- Reset, then MFC0 addr 15 → data_readFromCP0 = 32'h24. MFC0 addr 14 → 0. epc_ctrl = 0.
- MTC0 Status = 32'h0000_0301 (IE, IM0, IM1), raise interruptSignal[1], except_ret_addr = 32'h40 → one-cycle epc_ctrl with jump 32'h34 and exceptClear; EPC reads 32'h40; nest_level = 1.
- While servicing IRQ1: raise IRQ0 → no jump. Raise IRQ3 with IM3 set, ret 32'h80 → jump 32'h44, nest_level = 2. ERET → jump 32'h80. ERET → jump 32'h40, nest_level = 0.
- cause = 5'd2 and IRQ3 asserted in the same cycle, ret 32'h100 → jump 32'h24; ExcCode = 2; IRQ3 is not taken while lvl = N_IRQ+1.
- Fill the stack to NEST_DEPTH with nested exceptions, then raise one more → SOV = 1, nest_level stays NEST_DEPTH, top EPC replaced. ERET on an empty stack → no epc_ctrl.
- Assert rst while epc_ctrl is high → all outputs 0 immediately; EBASE restored to 32'h24.
